vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_prescaler.sv | 12 +
 rtl/vga_timing.sv | 67 ++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and counter types shared by the VGA timing block.
package vga_pkg;
  localparam int CNT_W = 10;
  localparam int H_VIS_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_VIS_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  localparam int H_TOTAL = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_prescaler.sv
// vga_prescaler: divides clk by 4 into a one-clk pixel strobe.
module vga_prescaler (
  input  logic clk,
  input  logic rst,
  output logic pixpulse
);
  logic [1:0] pre;
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= pre + 2'd1;
  assign pixpulse = pre == 2'd3;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster counters, sync/blank decode, frame counter and move request.
// Optional move divider enabled by defining VGA_MOVE_DIV_EN; otherwise move fires every frame.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS = H_VIS_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_VIS = V_VIS_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int MOVE_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pixpulse,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             move,
  output logic [15:0]      frame_cnt
);
  localparam cnt_t H_LAST = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VEND = cnt_t'(H_VIS);
  localparam cnt_t V_VEND = cnt_t'(V_VIS);
  localparam cnt_t HS_BEG = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_VIS + V_FP + V_SYNC);
  logic h_wrap, v_wrap, div_zero;
  vga_prescaler u_pre (.clk(clk), .rst(rst), .pixpulse(pixpulse));
  assign h_wrap = pixpulse && hcount == H_LAST;
  assign v_wrap = h_wrap && vcount == V_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pixpulse) begin
      hcount <= h_wrap ? '0 : hcount + cnt_t'(1);
      if (h_wrap) vcount <= v_wrap ? '0 : vcount + cnt_t'(1);
    end
  // Only written on the frame edge so the count holds between frames.
  always_ff @(posedge clk or posedge rst)
    if (rst) frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
`ifdef VGA_MOVE_DIV_EN
  localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);
  logic [7:0] div;
  always_ff @(posedge clk or posedge rst)
    if (rst) div <= '0;
    else if (v_wrap) div <= div == DIV_LAST ? '0 : div + 8'd1;
  assign div_zero = div == '0;
`else
  logic unused_move_div;
  assign unused_move_div = ^8'(MOVE_DIV);
  assign div_zero = 1'b1;
`endif
  assign hsync = !(hcount >= HS_BEG && hcount < HS_END);
  assign vsync = !(vcount >= VS_BEG && vcount < VS_END);
  assign blank = hcount >= H_VEND || vcount >= V_VEND;
  assign move = hcount == '0 && vcount == V_VEND && div_zero;
endmodule
